// File: rtl/ps2_key_mapper.sv
// PS/2 Scan Code Set 2 decoder: turns make/break byte sequences into the note gate,
// step pulses and ADSR selector consumed by the synth IO controller.
module ps2_key_mapper #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] scan_code,
    input  logic       scan_valid,
    output logic       note_in,
    output logic [3:0] note,
    output logic       note_trig,
    output logic       octave_plus_plus,
    output logic       octave_minus_minus,
    output logic       amp_plus_plus,
    output logic       amp_minus_minus,
    output logic [1:0] ADSR_selector,
    output logic       ADSR_plus_plus,
    output logic       ADSR_minus_minus
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_held_code;
    logic [4:0]       w_note_hit;

    // {is_note, note_number} for a make code
    function automatic logic [4:0] note_lookup(input logic [7:0] c);
        case (c)
            8'h1C: note_lookup = {1'b1, 4'd0};
            8'h1D: note_lookup = {1'b1, 4'd1};
            8'h1B: note_lookup = {1'b1, 4'd2};
            8'h24: note_lookup = {1'b1, 4'd3};
            8'h23: note_lookup = {1'b1, 4'd4};
            8'h2B: note_lookup = {1'b1, 4'd5};
            8'h2C: note_lookup = {1'b1, 4'd6};
            8'h34: note_lookup = {1'b1, 4'd7};
            8'h35: note_lookup = {1'b1, 4'd8};
            8'h33: note_lookup = {1'b1, 4'd9};
            8'h3C: note_lookup = {1'b1, 4'd10};
            8'h3B: note_lookup = {1'b1, 4'd11};
            8'h42: note_lookup = {1'b1, 4'd12};
            default: note_lookup = 5'd0;
        endcase
    endfunction

    assign w_note_hit = note_lookup(scan_code);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state            <= IDLE;
            r_cnt              <= '0;
            r_held_code        <= '0;
            note_in            <= 1'b0;
            note               <= '0;
            note_trig          <= 1'b0;
            octave_plus_plus   <= 1'b0;
            octave_minus_minus <= 1'b0;
            amp_plus_plus      <= 1'b0;
            amp_minus_minus    <= 1'b0;
            ADSR_selector      <= '0;
            ADSR_plus_plus     <= 1'b0;
            ADSR_minus_minus   <= 1'b0;
        end else begin
            note_trig          <= 1'b0;
            octave_plus_plus   <= 1'b0;
            octave_minus_minus <= 1'b0;
            amp_plus_plus      <= 1'b0;
            amp_minus_minus    <= 1'b0;
            ADSR_plus_plus     <= 1'b0;
            ADSR_minus_minus   <= 1'b0;

            // A byte always beats the timeout; it is decoded in the pending state
            if (scan_valid) begin
                r_cnt <= '0;
                case (r_state)
                    IDLE: begin
                        if (scan_code == 8'hF0) begin
                            r_state <= BRK;
                        end else if (scan_code == 8'hE0) begin
                            r_state <= EXT;
                        end else if (w_note_hit[4]) begin
                            if (!note_in || scan_code != r_held_code) begin
                                note        <= w_note_hit[3:0];
                                r_held_code <= scan_code;
                                note_in     <= 1'b1;
                                note_trig   <= 1'b1;
                            end
                        end else begin
                            case (scan_code)
                                8'h1A: octave_minus_minus <= 1'b1;
                                8'h22: octave_plus_plus   <= 1'b1;
                                8'h21: amp_minus_minus    <= 1'b1;
                                8'h2A: amp_plus_plus      <= 1'b1;
                                8'h16: ADSR_selector      <= 2'd0;
                                8'h1E: ADSR_selector      <= 2'd1;
                                8'h26: ADSR_selector      <= 2'd2;
                                8'h25: ADSR_selector      <= 2'd3;
                                8'h4E: ADSR_minus_minus   <= 1'b1;
                                8'h55: ADSR_plus_plus     <= 1'b1;
                                default: ;
                            endcase
                        end
                    end
                    BRK: begin
                        if (w_note_hit[4] && scan_code == r_held_code)
                            note_in <= 1'b0;
                        r_state <= IDLE;
                    end
                    EXT:     r_state <= (scan_code == 8'hF0) ? EXT_BRK : IDLE;
                    default: r_state <= IDLE;
                endcase
            end else if (r_state != IDLE) begin
                if (r_cnt == CNT_LAST) begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_mapper.sv
// Directed bench for ps2_key_mapper: byte sequences with hand-computed responses.
module tb_ps2_key_mapper;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] scan_code = 8'h00;
    logic       scan_valid = 1'b0;
    logic       note_in, note_trig;
    logic [3:0] note;
    logic       octave_plus_plus, octave_minus_minus;
    logic       amp_plus_plus, amp_minus_minus;
    logic [1:0] ADSR_selector;
    logic       ADSR_plus_plus, ADSR_minus_minus;
    logic [6:0] w_p;

    int total = 0;
    int bad = 0;

    ps2_key_mapper #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .scan_code(scan_code), .scan_valid(scan_valid),
        .note_in(note_in), .note(note), .note_trig(note_trig),
        .octave_plus_plus(octave_plus_plus), .octave_minus_minus(octave_minus_minus),
        .amp_plus_plus(amp_plus_plus), .amp_minus_minus(amp_minus_minus),
        .ADSR_selector(ADSR_selector),
        .ADSR_plus_plus(ADSR_plus_plus), .ADSR_minus_minus(ADSR_minus_minus)
    );

    always #5 clk = ~clk;

    // pulse order: trig, oct+, oct-, amp+, amp-, adsr+, adsr-
    assign w_p = {note_trig, octave_plus_plus, octave_minus_minus,
                  amp_plus_plus, amp_minus_minus, ADSR_plus_plus, ADSR_minus_minus};

    // Called at a falling edge; returns at the falling edge after the capturing rising edge
    task automatic send(input logic [7:0] b);
        scan_code  = b;
        scan_valid = 1'b1;
        @(negedge clk);
        scan_valid = 1'b0;
        scan_code  = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        total++; if (w_p !== 7'b0) begin bad++; $display("FAIL rst_pulses got=%b exp=%b", w_p, 7'b0); end
        total++; if ({note_in, note, ADSR_selector} !== 7'b0) begin bad++; $display("FAIL rst_state got=%b exp=%b", {note_in, note, ADSR_selector}, 7'b0); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        pulse_reset();
        total++; if ({w_p, note_in, note, ADSR_selector} !== 14'b0) begin bad++; $display("FAIL reset_release got=%b exp=%b", {w_p, note_in, note, ADSR_selector}, 14'b0); end
    endtask

    task automatic test_note_basic();
        send(8'h1C);
        total++; if ({w_p, note_in, note} !== {7'b1000000, 1'b1, 4'd0}) begin bad++; $display("FAIL make1C got=%b exp=%b", {w_p, note_in, note}, {7'b1000000, 1'b1, 4'd0}); end
        idle(1);
        total++; if (w_p !== 7'b0) begin bad++; $display("FAIL trig_one_cycle got=%b exp=%b", w_p, 7'b0); end
        send(8'hF0);
        total++; if ({w_p, note_in} !== 8'b00000001) begin bad++; $display("FAIL f0_noeffect got=%b exp=%b", {w_p, note_in}, 8'b00000001); end
        send(8'h1C);
        total++; if ({w_p, note_in, note} !== 12'b0) begin bad++; $display("FAIL break1C got=%b exp=%b", {w_p, note_in, note}, 12'b0); end
    endtask

    task automatic test_last_priority();
        send(8'h1C);
        total++; if ({note_trig, note} !== {1'b1, 4'd0}) begin bad++; $display("FAIL lp_make1C got=%b exp=%b", {note_trig, note}, {1'b1, 4'd0}); end
        send(8'h24);
        total++; if ({note_trig, note_in, note} !== {1'b1, 1'b1, 4'd3}) begin bad++; $display("FAIL lp_make24 got=%b exp=%b", {note_trig, note_in, note}, {1'b1, 1'b1, 4'd3}); end
        send(8'hF0); send(8'h1C);
        total++; if ({w_p, note_in, note} !== {7'b0, 1'b1, 4'd3}) begin bad++; $display("FAIL lp_break_old got=%b exp=%b", {w_p, note_in, note}, {7'b0, 1'b1, 4'd3}); end
        send(8'hF0); send(8'h24);
        total++; if ({note_in, note} !== {1'b0, 4'd3}) begin bad++; $display("FAIL lp_break_held got=%b exp=%b", {note_in, note}, {1'b0, 4'd3}); end
    endtask

    task automatic test_typematic();
        send(8'h23);
        total++; if ({note_trig, note_in, note} !== {1'b1, 1'b1, 4'd4}) begin bad++; $display("FAIL tm_first got=%b exp=%b", {note_trig, note_in, note}, {1'b1, 1'b1, 4'd4}); end
        for (int i = 0; i < 2; i++) begin
            send(8'h23);
            total++; if ({w_p, note_in, note} !== {7'b0, 1'b1, 4'd4}) begin bad++; $display("FAIL tm_repeat%0d got=%b exp=%b", i, {w_p, note_in, note}, {7'b0, 1'b1, 4'd4}); end
        end
        send(8'hF0); send(8'h23);
        total++; if (note_in !== 1'b0) begin bad++; $display("FAIL tm_release got=%b exp=0", note_in); end
    endtask

    task automatic test_controls();
        send(8'h22);
        total++; if (w_p !== 7'b0100000) begin bad++; $display("FAIL oct_plus1 got=%b exp=%b", w_p, 7'b0100000); end
        idle(1);
        total++; if (w_p !== 7'b0) begin bad++; $display("FAIL oct_one_cycle got=%b exp=%b", w_p, 7'b0); end
        send(8'h22);
        total++; if (w_p !== 7'b0100000) begin bad++; $display("FAIL oct_plus2 got=%b exp=%b", w_p, 7'b0100000); end
        send(8'h1A);
        total++; if (w_p !== 7'b0010000) begin bad++; $display("FAIL oct_minus got=%b exp=%b", w_p, 7'b0010000); end
        send(8'hF0); send(8'h22);
        total++; if (w_p !== 7'b0) begin bad++; $display("FAIL oct_break got=%b exp=%b", w_p, 7'b0); end
        send(8'h26);
        total++; if ({w_p, ADSR_selector} !== {7'b0, 2'd2}) begin bad++; $display("FAIL adsr_sel got=%b exp=%b", {w_p, ADSR_selector}, {7'b0, 2'd2}); end
        send(8'h55);
        total++; if ({w_p, ADSR_selector} !== {7'b0000010, 2'd2}) begin bad++; $display("FAIL adsr_plus got=%b exp=%b", {w_p, ADSR_selector}, {7'b0000010, 2'd2}); end
        send(8'h4E);
        total++; if ({w_p, ADSR_selector} !== {7'b0000001, 2'd2}) begin bad++; $display("FAIL adsr_minus got=%b exp=%b", {w_p, ADSR_selector}, {7'b0000001, 2'd2}); end
        send(8'h25);
        total++; if (ADSR_selector !== 2'd3) begin bad++; $display("FAIL adsr_sel3 got=%0d exp=3", ADSR_selector); end
        send(8'hAA);
        total++; if ({w_p, note_in, ADSR_selector} !== {7'b0, 1'b0, 2'd3}) begin bad++; $display("FAIL ignored_AA got=%b exp=%b", {w_p, note_in, ADSR_selector}, {7'b0, 1'b0, 2'd3}); end
    endtask

    task automatic test_back_to_back();
        scan_valid = 1'b1;
        scan_code  = 8'h2A;
        @(negedge clk);
        scan_code  = 8'h21;
        total++; if (w_p !== 7'b0001000) begin bad++; $display("FAIL b2b_amp_plus got=%b exp=%b", w_p, 7'b0001000); end
        @(negedge clk);
        scan_code  = 8'h16;
        total++; if (w_p !== 7'b0000100) begin bad++; $display("FAIL b2b_amp_minus got=%b exp=%b", w_p, 7'b0000100); end
        @(negedge clk);
        scan_valid = 1'b0;
        scan_code  = 8'h00;
        total++; if ({w_p, ADSR_selector} !== {7'b0, 2'd0}) begin bad++; $display("FAIL b2b_sel0 got=%b exp=%b", {w_p, ADSR_selector}, {7'b0, 2'd0}); end
    endtask

    task automatic test_prefix();
        send(8'hE0); send(8'h1C);
        total++; if ({w_p, note_in, note} !== {7'b0, 1'b0, 4'd4}) begin bad++; $display("FAIL ext_discard got=%b exp=%b", {w_p, note_in, note}, {7'b0, 1'b0, 4'd4}); end
        send(8'hE0); send(8'hF0); send(8'h1C);
        total++; if ({w_p, note_in} !== 8'b0) begin bad++; $display("FAIL extbrk_discard got=%b exp=%b", {w_p, note_in}, 8'b0); end
        send(8'h1C);
        total++; if ({note_trig, note_in, note} !== {1'b1, 1'b1, 4'd0}) begin bad++; $display("FAIL after_ext_make got=%b exp=%b", {note_trig, note_in, note}, {1'b1, 1'b1, 4'd0}); end
        // short gap stays within the break prefix window
        send(8'hF0); idle(5); send(8'h1C);
        total++; if (note_in !== 1'b0) begin bad++; $display("FAIL brk_short_gap got=%b exp=0", note_in); end
        send(8'hF0); idle(TO + 4); send(8'h1C);
        total++; if ({note_trig, note_in, note} !== {1'b1, 1'b1, 4'd0}) begin bad++; $display("FAIL timeout_make got=%b exp=%b", {note_trig, note_in, note}, {1'b1, 1'b1, 4'd0}); end
        send(8'hF0);
        pulse_reset();
        total++; if ({note_in, note} !== 5'b0) begin bad++; $display("FAIL mid_reset_clear got=%b exp=%b", {note_in, note}, 5'b0); end
        send(8'h2A);
        total++; if (w_p !== 7'b0001000) begin bad++; $display("FAIL reset_then_amp got=%b exp=%b", w_p, 7'b0001000); end
    endtask

    initial begin
        test_reset();
        test_note_basic();
        test_last_priority();
        test_typematic();
        test_controls();
        test_back_to_back();
        test_prefix();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
